// File: rtl/shift_pkg.sv
// Shared constants for the shift execute stage: funct encodings and datapath widths.
package shift_pkg;

    localparam logic [1:0] FN_SLL = 2'b00;
    localparam logic [1:0] FN_RSV = 2'b01;
    localparam logic [1:0] FN_SRL = 2'b10;
    localparam logic [1:0] FN_SRA = 2'b11;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    function automatic logic is_reserved(input logic [1:0] funct);
        return funct == FN_RSV;
    endfunction

endpackage

// File: rtl/Shifter.sv
// Combinational 32-bit shifter: SLL/SRL zero-fill, SRA sign-fills from bit 31.
module Shifter
    import shift_pkg::*;
(
    input  logic [1:0]         funct,
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] N,
    output logic [DATA_W-1:0]  R
);

    always_comb begin
        R = '0;
        case (funct)
            FN_SLL:  R = a << N;
            FN_SRL:  R = a >> N;
            FN_SRA:  R = $unsigned($signed(a) >>> N);
            default: R = '0;
        endcase
    end

endmodule

// File: rtl/shift_stage.sv
// Two-register execute stage around Shifter: S1 holds the decoded operation,
// S2 holds the tagged result, both with valid/ready back-pressure.
module shift_stage
    import shift_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_funct,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [DATA_W-1:0]  in_rs,
    input  logic               in_var,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_r,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   op_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // in_ready depends combinationally on out_ready through the advance chain.
    logic               r_s1_valid;
    logic [1:0]         r_s1_funct;
    logic [DATA_W-1:0]  r_s1_a;
    logic [SHAMT_W-1:0] r_s1_amt;
    logic [TAG_W-1:0]   r_s1_tag;

    logic               r_s2_valid;
    logic [DATA_W-1:0]  r_s2_r;
    logic [TAG_W-1:0]   r_s2_tag;
    logic               r_s2_illegal;
    logic [CNT_W-1:0]   r_count;

    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_accept;
    logic [SHAMT_W-1:0] w_amt;
    logic [DATA_W-1:0]  w_shift_r;
    logic               w_s1_rsv;
    logic               w_unused_rs_hi;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = in_valid && w_s1_adv;
    assign w_amt    = in_var ? in_rs[SHAMT_W-1:0] : in_shamt;
    assign w_s1_rsv = is_reserved(r_s1_funct);

    // Only the low amount bits of the register operand matter.
    assign w_unused_rs_hi = ^in_rs[DATA_W-1:SHAMT_W];

    Shifter u_shifter (
        .funct (r_s1_funct),
        .a     (r_s1_a),
        .N     (r_s1_amt),
        .R     (w_shift_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_funct <= FN_SLL;
            r_s1_a     <= '0;
            r_s1_amt   <= '0;
            r_s1_tag   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_funct <= in_funct;
                r_s1_a     <= in_a;
                r_s1_amt   <= w_amt;
                r_s1_tag   <= in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid   <= 1'b0;
            r_s2_r       <= '0;
            r_s2_tag     <= '0;
            r_s2_illegal <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_r       <= w_s1_rsv ? '0 : w_shift_r;
                r_s2_tag     <= r_s1_tag;
                r_s2_illegal <= w_s1_rsv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign in_ready    = w_s1_adv;
    assign out_valid   = r_s2_valid;
    assign out_r       = r_s2_r;
    assign out_tag     = r_s2_tag;
    assign out_illegal = r_s2_illegal;
    assign op_count    = r_count;

endmodule
